jt9346_host: RTL and testbench

Serial host (initiator) for 93C46/93C06-compatible EEPROMs, including the team's jt9346 model. Accepts one command at a time on a valid/ready interface and generates scs/sclk/sdi frames. Captures read data from sdo and polls ready/busy after programming commands. Sits between game/CPU glue logic and the NVRAM chip.

---
 rtl/jt9346_host.sv | 258 +++++++++++++++++++++++++
 tb/tb_jt9346_host.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt9346_host.sv
// Serial host for 93C46/93C06-style EEPROMs: one command per handshake,
// emits the scs/sclk/sdi frame, collects read data and polls ready/busy.
module jt9346_host #(
  parameter int AW    = 6,
  parameter int CW    = AW,
  parameter int DW    = 16,
  parameter int DIV   = 4,
  parameter int CSGAP = 4,
  parameter int TOUT  = 20'hFFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_din,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          err,
  output logic          sclk,
  output logic          sdi,
  output logic          scs,
  input  logic          sdo
);

  // state | meaning
  // IDLE  | waiting for a command
  // SETUP | scs high, CSGAP wait before the first bit
  // SHIFT | dummy, start, opcode, address and optional data bits
  // RDIN  | DW+1 read pulses, sdo captured before each rising edge
  // GAP   | scs low CSGAP cycles after the frame
  // POLL  | scs high, waiting for sdo=1 or timeout
  // FIN   | deselected; done pulses on the following cycle
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_RDIN, S_GAP, S_POLL, S_FIN
  } state_t;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_EWDS  = 3'd4;
  localparam logic [2:0] OP_ERAL  = 3'd5;
  localparam logic [2:0] OP_WRAL  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam int FW  = 4 + CW + DW;
  localparam int BCW = $clog2(FW + 1);
  localparam int DVW = $clog2(DIV + 1);
  localparam int TMX = (TOUT > CSGAP) ? TOUT : CSGAP;
  localparam int TW  = $clog2(TMX + 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [FW-1:0]   sh_q, sh_d;
  logic [BCW-1:0]  bit_q, bit_d;
  logic [DVW-1:0]  div_q, div_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   rd_sh_q, rd_sh_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            sclk_q, sclk_d;
  logic            sdi_q, sdi_d;
  logic            scs_q, scs_d;

  logic [CW-1:0]   afield;
  logic [1:0]      opc;
  logic [DW-1:0]   dfield;
  logic            has_data, is_prog;

  assign has_data = (op_q == OP_WRITE) || (op_q == OP_WRAL);
  assign is_prog  = has_data || (op_q == OP_ERASE) || (op_q == OP_ERAL);

  // Extended ops put their sub-code in the top two address-field bits.
  always_comb begin
    afield = CW'(cmd_addr);
    opc    = 2'b00;
    dfield = '0;
    case (cmd_op)
      OP_READ:  opc = 2'b10;
      OP_WRITE: begin opc = 2'b01; dfield = cmd_din; end
      OP_ERASE: opc = 2'b11;
      OP_EWEN:  begin afield = '0; afield[CW-1 -: 2] = 2'b11; end
      OP_EWDS:  afield = '0;
      OP_ERAL:  begin afield = '0; afield[CW-1 -: 2] = 2'b10; end
      OP_WRAL:  begin afield = '0; afield[CW-1 -: 2] = 2'b01; dfield = cmd_din; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    div_d     = div_q;
    tmr_d     = tmr_q;
    rd_sh_d   = rd_sh_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    sclk_d    = sclk_q;
    sdi_d     = sdi_q;
    scs_d     = scs_q;
    done_d    = (state_q == S_FIN);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d  = cmd_op;
          err_d = 1'b0;
          sh_d  = {2'b01, opc, afield, dfield};
          if (cmd_op == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            scs_d   = 1'b1;
            tmr_d   = TW'(CSGAP - 1);
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else begin
          state_d = S_SHIFT;
          bit_d   = has_data ? BCW'(FW - 1) : BCW'(FW - DW - 1);
          sdi_d   = sh_q[FW-1];
          sh_d    = sh_q << 1;
          div_d   = DVW'(DIV - 1);
        end
      end
      S_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DVW'(1);
        end else begin
          div_d = DVW'(DIV - 1);
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q != '0) begin
            bit_d  = bit_q - BCW'(1);
            sclk_d = 1'b0;
            sdi_d  = sh_q[FW-1];
            sh_d   = sh_q << 1;
          end else begin
            sclk_d = 1'b0;
            sdi_d  = 1'b0;
            if (op_q == OP_READ) begin
              state_d = S_RDIN;
              bit_d   = BCW'(DW);
            end else begin
              state_d = S_GAP;
              scs_d   = 1'b0;
              tmr_d   = TW'(CSGAP - 1);
            end
          end
        end
      end
      S_RDIN: begin
        if (div_q != '0) begin
          div_d = div_q - DVW'(1);
        end else begin
          div_d = DVW'(DIV - 1);
          if (!sclk_q) begin
            sclk_d = 1'b1;
            // first pulse carries the chip's dummy 0
            if (bit_q == BCW'(DW)) begin
              if (sdo) err_d = 1'b1;
            end else begin
              rd_sh_d = {rd_sh_q[DW-2:0], sdo};
            end
          end else if (bit_q != '0) begin
            bit_d  = bit_q - BCW'(1);
            sclk_d = 1'b0;
          end else begin
            sclk_d  = 1'b0;
            scs_d   = 1'b0;
            state_d = S_FIN;
          end
        end
      end
      S_GAP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (is_prog) begin
          state_d = S_POLL;
          scs_d   = 1'b1;
          tmr_d   = TW'(TOUT - 2);
        end else begin
          state_d = S_FIN;
        end
      end
      S_POLL: begin
        // TOUT counts from scs rise to the done pulse
        if (sdo) begin
          state_d = S_FIN;
          scs_d   = 1'b0;
        end else if (tmr_q == '0) begin
          state_d = S_FIN;
          scs_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        scs_d   = 1'b0;
        sclk_d  = 1'b0;
        sdi_d   = 1'b0;
        if (op_q == OP_READ) rd_data_d = rd_sh_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_READ;
      sh_q      <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      tmr_q     <= '0;
      rd_sh_q   <= '0;
      rd_data_q <= '1;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdi_q     <= 1'b0;
      scs_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      tmr_q     <= tmr_d;
      rd_sh_q   <= rd_sh_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sdi_q     <= sdi_d;
      scs_q     <= scs_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !done_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q & done_q;
  assign sclk      = sclk_q;
  assign sdi       = sdi_q;
  assign scs       = scs_q;

endmodule

// File: tb/tb_jt9346_host.sv
// Directed bench for jt9346_host with a small behavioural 93C46 model and a
// scoreboard of per-command expectations popped when done pulses.
module tb_jt9346_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [5:0]  cmd_addr = 6'd0;
  logic [15:0] cmd_din = 16'd0;
  logic [15:0] rd_data;
  logic        done, err, sclk, sdi, scs;
  logic        sdo = 1'b1;

  jt9346_host #(.AW(6), .CW(6), .DW(16), .DIV(2), .CSGAP(4), .TOUT(100)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_din(cmd_din), .rd_data(rd_data),
    .done(done), .err(err), .sclk(sclk), .sdi(sdi), .scs(scs), .sdo(sdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // EEPROM model, evaluated on the falling clk edge
  logic [15:0] mem [64];
  logic        mem_init = 1'b0;
  logic        ew_en = 1'b0;
  logic        started = 1'b0;
  logic        reading = 1'b0;
  logic        sdo_m = 1'b0;
  logic        stuck_busy = 1'b0;
  logic        sclk_prev = 1'b0;
  logic        scs_prev = 1'b0;
  logic [23:0] rx = '0;
  logic [15:0] rd_word = '0;
  int          nrx = 0;
  int          busy = 0;
  int          sclk_rises = 0;
  int          scs_rises = 0;
  int          last_scs_rise = 0;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem_init = 1'b1;
    end
    if (busy > 0) busy--;
    if (scs && !scs_prev) begin
      scs_rises++;
      last_scs_rise = cyc;
    end
    if (scs && sclk && !sclk_prev) begin
      sclk_rises++;
      if (!started) begin
        if (sdi) begin
          started = 1'b1;
          nrx = 0;
        end
      end else begin
        rx = {rx[22:0], sdi};
        nrx++;
        if (nrx == 8 && rx[7:6] == 2'b10) begin
          reading = 1'b1;
          rd_word = mem[rx[5:0]];
          sdo_m = 1'b0;
        end else if (reading) begin
          sdo_m = rd_word[15];
          rd_word = rd_word << 1;
        end
      end
    end
    if (!scs && scs_prev && started) begin
      if (nrx == 8) begin
        if (rx[7:6] == 2'b11 && ew_en) begin
          mem[rx[5:0]] = 16'hFFFF;
          busy = 20;
        end else if (rx[7:6] == 2'b00) begin
          case (rx[5:4])
            2'b11: ew_en = 1'b1;
            2'b00: ew_en = 1'b0;
            2'b10: if (ew_en) begin
              for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
              busy = 20;
            end
            default: ;
          endcase
        end
      end else if (nrx == 24 && ew_en) begin
        if (rx[23:22] == 2'b01) begin
          mem[rx[21:16]] = rx[15:0];
          busy = 20;
        end else if (rx[23:22] == 2'b00 && rx[21:20] == 2'b01) begin
          for (int i = 0; i < 64; i++) mem[i] = rx[15:0];
          busy = 20;
        end
      end
    end
    if (!scs && scs_prev) begin
      started = 1'b0;
      reading = 1'b0;
      nrx = 0;
      sdo_m = 1'b0;
    end
    sclk_prev = sclk;
    scs_prev = scs;
    sdo = started ? sdo_m : ((busy == 0) && !stuck_busy);
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        err;
    logic        chk_rd;
    logic [15:0] rd;
    int          edges;
    int          lat;
    int          poll;
  } exp_t;
  exp_t sb[$];

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [5:0] addr,
                         input logic [15:0] din, input logic e_err, input logic e_chk_rd,
                         input logic [15:0] e_rd, input int e_edges, input int e_lat,
                         input int e_poll);
    exp_t g;
    int   e0, lat, n;
    bit   seen;
    sb.push_back('{tag, e_err, e_chk_rd, e_rd, e_edges, e_lat, e_poll});
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = addr;
    cmd_din = din;
    e0 = sclk_rises;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk({tag, " ready_drop"}, 32'(cmd_ready), 32'd0);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    g = sb.pop_front();
    chk({g.tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({g.tag, " err"}, 32'(err), 32'(g.err));
      chk({g.tag, " scs_at_done"}, 32'(scs), 32'd0);
      chk({g.tag, " ready_at_done"}, 32'(cmd_ready), 32'd0);
      chk({g.tag, " sclk_edges"}, 32'(sclk_rises - e0), 32'(g.edges));
      if (g.chk_rd) chk({g.tag, " rd_data"}, 32'(rd_data), 32'(g.rd));
      if (g.lat >= 0) chk({g.tag, " latency"}, 32'(lat), 32'(g.lat));
      if (g.poll >= 0) chk({g.tag, " poll_len"}, 32'(cyc - last_scs_rise), 32'(g.poll));
      @(negedge clk);
      chk({g.tag, " done_pulse"}, 32'(done), 32'd0);
      chk({g.tag, " ready_after"}, 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    int s0, e0, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst rd_data", 32'(rd_data), 32'hFFFF);
    chk("rst sclk", 32'(sclk), 32'd0);
    chk("rst sdi", 32'(sdi), 32'd0);
    chk("rst scs", 32'(scs), 32'd0);

    run_cmd("ewen", 3'd3, 6'd0, 16'h0, 1'b0, 1'b0, 16'h0, 10, -1, -1);
    run_cmd("write5", 3'd1, 6'h05, 16'hA55A, 1'b0, 1'b0, 16'h0, 26, -1, -1);
    chk("model mem5", 32'(mem[5]), 32'hA55A);
    run_cmd("read5", 3'd0, 6'h05, 16'h0, 1'b0, 1'b1, 16'hA55A, 27, -1, -1);

    run_cmd("wral", 3'd6, 6'd0, 16'h1234, 1'b0, 1'b0, 16'h0, 26, -1, -1);
    run_cmd("read0", 3'd0, 6'd0, 16'h0, 1'b0, 1'b1, 16'h1234, 27, -1, -1);
    run_cmd("read63", 3'd0, 6'd63, 16'h0, 1'b0, 1'b1, 16'h1234, 27, -1, -1);

    run_cmd("ewen2", 3'd3, 6'd0, 16'h0, 1'b0, 1'b0, 16'h0, 10, -1, -1);
    run_cmd("erase3", 3'd2, 6'd3, 16'h0, 1'b0, 1'b0, 16'h0, 10, -1, -1);
    run_cmd("read3", 3'd0, 6'd3, 16'h0, 1'b0, 1'b1, 16'hFFFF, 27, -1, -1);

    stuck_busy = 1'b1;
    run_cmd("timeout", 3'd1, 6'd7, 16'h5AA5, 1'b1, 1'b0, 16'h0, 26, -1, 100);
    chk("timeout scs_after", 32'(scs), 32'd0);
    stuck_busy = 1'b0;

    s0 = scs_rises;
    run_cmd("rsvd", 3'd7, 6'd0, 16'h0, 1'b1, 1'b0, 16'h0, 0, 2, -1);
    chk("rsvd scs_rises", 32'(scs_rises - s0), 32'd0);

    // abandon a READ while sclk is high on the start bit
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_addr = 6'h05;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(sclk && sdi && scs) && n < 500) begin @(negedge clk); n++; end
    chk("abort reached_frame", 32'(sclk && sdi && scs), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort scs", 32'(scs), 32'd0);
    chk("abort sclk", 32'(sclk), 32'd0);
    chk("abort sdi", 32'(sdi), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready", 32'(cmd_ready), 32'd1);
    chk("abort done", 32'(done), 32'd0);

    run_cmd("read5b", 3'd0, 6'h05, 16'h0, 1'b0, 1'b1, 16'h1234, 27, -1, -1);
    run_cmd("ewds", 3'd4, 6'd0, 16'h0, 1'b0, 1'b0, 16'h0, 10, -1, -1);
    run_cmd("write_dis", 3'd1, 6'h05, 16'hBEEF, 1'b0, 1'b0, 16'h0, 26, -1, -1);
    run_cmd("read5c", 3'd0, 6'h05, 16'h0, 1'b0, 1'b1, 16'h1234, 27, -1, -1);

    e0 = sb.size();
    chk("scoreboard empty", 32'(e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
